// File: rtl/rd_memory.sv
// Read-side FIFO memory: captures a parallel image on load, then drains it
// one entry per rd_en in address order. It flags empty, overrun and underrun.
module rd_memory #(
  parameter int RD_DATA_WIDTH = 1,
  parameter int RD_ADDR_WIDTH = 3,
  parameter int MEM_DEPTH     = 8
) (
  input  logic                               rd_clk,
  input  logic                               reset,
  input  logic [MEM_DEPTH*RD_DATA_WIDTH-1:0] remapping_memory,
  input  logic                               load,
  input  logic                               rd_en,
  output logic [RD_DATA_WIDTH-1:0]           rd_data,
  output logic                               rd_valid,
  output logic [RD_ADDR_WIDTH-1:0]           rd_addr,
  output logic [RD_ADDR_WIDTH:0]             count,
  output logic                               empty,
  output logic                               overrun,
  output logic                               underrun
);

  typedef enum logic {EMPTY, READING} state_t;

  localparam logic [RD_ADDR_WIDTH-1:0] ADDR_LAST = RD_ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [RD_ADDR_WIDTH:0]   CNT_FULL  = (RD_ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [RD_ADDR_WIDTH:0]   CNT_ONE   = (RD_ADDR_WIDTH + 1)'(1);

  state_t                    state, state_nxt;
  logic [RD_DATA_WIDTH-1:0]  bank [MEM_DEPTH];
  logic [RD_ADDR_WIDTH-1:0]  addr_nxt;
  logic [RD_ADDR_WIDTH:0]    count_nxt;
  logic                      rd_fire, last_read, load_accept;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_nxt   = state;
    addr_nxt    = rd_addr;
    count_nxt   = count;
    rd_fire     = rd_en && (state == READING);
    last_read   = rd_fire && (count == CNT_ONE);
    load_accept = load && ((state == EMPTY) || last_read);

    if (rd_fire) begin
      // Wrap at MEM_DEPTH, which need not be a power of two.
      addr_nxt  = (rd_addr == ADDR_LAST) ? '0 : rd_addr + 1'b1;
      count_nxt = count - 1'b1;
      if (last_read) state_nxt = EMPTY;
    end
    // A reload that coincides with the last read overrides the drain updates.
    if (load_accept) begin
      addr_nxt  = '0;
      count_nxt = CNT_FULL;
      state_nxt = READING;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      state    <= EMPTY;
      rd_addr  <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      empty    <= 1'b1;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_addr  <= addr_nxt;
      count    <= count_nxt;
      rd_valid <= rd_fire;
      empty    <= (state_nxt == EMPTY);
      overrun  <= load && !load_accept;
      underrun <= rd_en && (state == EMPTY);
      if (rd_fire) rd_data <= bank[rd_addr];
    end
  end

  // NOTE: the bank is small and must read as zero after reset, so it is
  // reset explicitly rather than left as uninitialised storage.
  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) bank[i] <= '0;
    end else if (load_accept) begin
      for (int i = 0; i < MEM_DEPTH; i++)
        bank[i] <= remapping_memory[i*RD_DATA_WIDTH +: RD_DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_rd_memory.sv
// Self-checking bench for rd_memory: directed scenarios plus random traffic
// checked against a queue-based model of the unread entries.
module tb_rd_memory;

  logic       rd_clk;
  logic       reset;
  logic [7:0] remapping_memory;
  logic       load, rd_en;
  logic       rd_data, rd_valid;
  logic [2:0] rd_addr;
  logic [3:0] count;
  logic       empty, overrun, underrun;

  logic [5:0] img6;
  logic       load6, rd_en6;
  logic       rd_data6, rd_valid6;
  logic [2:0] rd_addr6;
  logic [3:0] count6;
  logic       empty6, overrun6, underrun6;

  rd_memory #(.RD_DATA_WIDTH(1), .RD_ADDR_WIDTH(3), .MEM_DEPTH(8)) dut (
    .rd_clk(rd_clk), .reset(reset), .remapping_memory(remapping_memory),
    .load(load), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .count(count), .empty(empty),
    .overrun(overrun), .underrun(underrun)
  );

  rd_memory #(.RD_DATA_WIDTH(1), .RD_ADDR_WIDTH(3), .MEM_DEPTH(6)) dut6 (
    .rd_clk(rd_clk), .reset(reset), .remapping_memory(img6),
    .load(load6), .rd_en(rd_en6), .rd_data(rd_data6), .rd_valid(rd_valid6),
    .rd_addr(rd_addr6), .count(count6), .empty(empty6),
    .overrun(overrun6), .underrun(underrun6)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Model: the queue holds exactly the unread entries, in read order.
  logic q[$];
  logic exp_valid, exp_data, exp_over, exp_under;

  function automatic logic [11:0] dut_vec();
    return {rd_valid, rd_data, count, rd_addr, empty, overrun, underrun};
  endfunction

  function automatic logic [11:0] exp_vec();
    int n = q.size();
    return {exp_valid, exp_data, 4'(n), 3'((8 - n) % 8), (n == 0), exp_over, exp_under};
  endfunction

  task automatic model_reset();
    q.delete();
    exp_valid = 0; exp_data = 0; exp_over = 0; exp_under = 0;
  endtask

  // Drive one cycle, advance the model, and return 1 ns after the edge.
  task automatic step(input logic ld, input logic re, input logic [7:0] img);
    int n;
    bit accept;
    load = ld; rd_en = re; remapping_memory = img;
    @(posedge rd_clk);
    n = q.size();
    accept    = ld && (n == 0 || (n == 1 && re));
    exp_valid = re && n > 0;
    exp_under = re && n == 0;
    exp_over  = ld && !accept;
    if (exp_valid) exp_data = q.pop_front();
    if (accept) begin
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(img[i]);
    end
    #1;
    load = 0; rd_en = 0;
  endtask

  task automatic test_reset();
    reset = 0; load = 0; rd_en = 0; remapping_memory = '0;
    load6 = 0; rd_en6 = 0; img6 = '0;
    model_reset();
    #12;
    n_cmp++;
    if (dut_vec() !== 12'b0_0_0000_000_1_0_0) begin
      n_err++; $display("FAIL reset: got %b want %b", dut_vec(), 12'b0_0_0000_000_1_0_0);
    end
    #10 reset = 1;
  endtask

  task automatic test_drain();
    logic [7:0] seq = 8'b1011_0010;
    step(1, 0, seq);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL drain_load: got %b want %b", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'hxx);
      n_cmp++;
      if (dut_vec() !== exp_vec() || rd_data !== seq[i] || rd_valid !== 1'b1) begin
        n_err++; $display("FAIL drain_read%0d: got %b want %b bit %b", i, dut_vec(), exp_vec(), seq[i]);
      end
    end
    n_cmp++;
    if (empty !== 1'b1 || rd_addr !== 3'd0 || count !== 4'd0) begin
      n_err++; $display("FAIL drain_end: got empty=%b addr=%0d count=%0d want 1/0/0", empty, rd_addr, count);
    end
  endtask

  task automatic test_overrun();
    step(1, 0, 8'hFF);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00);
    step(1, 0, 8'h00);
    n_cmp++;
    if (overrun !== 1'b1 || count !== 4'd5 || dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL overrun_pulse: got %b want %b", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h00);
      n_cmp++;
      if (rd_data !== 1'b1 || rd_valid !== 1'b1 || overrun !== 1'b0 || dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL overrun_read%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 8'h00);
      n_cmp++;
      if (underrun !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 1'b1 || dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL underrun%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    step(0, 0, 8'h00);
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_err++; $display("FAIL underrun_clear: got %b want 0", underrun);
    end
  endtask

  task automatic test_last_read_reload();
    logic [7:0] seq = 8'h3C;
    step(1, 0, 8'hA5);
    for (int i = 0; i < 7; i++) step(0, 1, 8'h00);
    step(1, 1, seq);
    n_cmp++;
    if (rd_data !== 1'b1 || rd_valid !== 1'b1 || count !== 4'd8 || rd_addr !== 3'd0 ||
        empty !== 1'b0 || overrun !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL reload_same_cycle: got %b want %b", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 8'h00);
      n_cmp++;
      if (rd_data !== seq[i] || dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reload_read%0d: got %b want %b bit %b", i, dut_vec(), exp_vec(), seq[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 8'hF0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'h00);
    #3 reset = 0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec() !== 12'b0_0_0000_000_1_0_0) begin
      n_err++; $display("FAIL async_reset: got %b want %b", dut_vec(), 12'b0_0_0000_000_1_0_0);
    end
    #2 reset = 1;
    step(0, 1, 8'h00);
    n_cmp++;
    if (underrun !== 1'b1 || rd_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_err++; $display("FAIL post_reset_underrun: got %b want %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7, 8'($urandom));
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random cyc%0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_depth6();
    logic [5:0] seq = 6'b101010;
    logic [2:0] addr_seq [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    load6 = 1; img6 = seq;
    @(posedge rd_clk); #1;
    load6 = 0;
    n_cmp++;
    if (count6 !== 4'd6 || empty6 !== 1'b0 || rd_addr6 !== 3'd0) begin
      n_err++; $display("FAIL d6_load: got count=%0d empty=%b addr=%0d want 6/0/0", count6, empty6, rd_addr6);
    end
    for (int i = 0; i < 6; i++) begin
      rd_en6 = 1;
      @(posedge rd_clk); #1;
      rd_en6 = 0;
      n_cmp++;
      if (rd_addr6 !== addr_seq[i] || rd_data6 !== seq[i] || rd_valid6 !== 1'b1 ||
          count6 !== 4'(5 - i)) begin
        n_err++; $display("FAIL d6_read%0d: got addr=%0d data=%b valid=%b count=%0d want %0d/%b/1/%0d",
                          i, rd_addr6, rd_data6, rd_valid6, count6, addr_seq[i], seq[i], 5 - i);
      end
    end
    n_cmp++;
    if (empty6 !== 1'b1) begin
      n_err++; $display("FAIL d6_empty: got %b want 1", empty6);
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_overrun();
    test_underrun();
    test_last_read_reload();
    test_async_reset();
    test_random();
    test_depth6();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
